fp32_to_fp16_pipe: RTL and testbench

Multi-lane, pipelined FP32→FP16 converter with valid/ready streaming, IEEE round-to-nearest-even, NaN/Inf preservation, optional saturation and per-lane exception flags. It is the streaming successor to the single-word truncating converter. It sits between FP32 accumulators and FP16 buffers / off-chip writeback, converting `LANES` values per beat at one beat per cycle.

---
 rtl/fp_cvt_pkg.sv | 12 +
 rtl/fp32_to_fp16_rne_lane.sv | 149 ++++++++++++++
 rtl/fp32_to_fp16_pipe.sv | 54 +++++
 tb/tb_fp32_to_fp16_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cvt_pkg.sv
// rtl/fp_cvt_pkg.sv - shared constants and lane classification for the FP32->FP16 converter
package fp_cvt_pkg;
    localparam int FP32_BIAS = 127;
    localparam int FP16_BIAS = 15;
    localparam int EXP_ADJ   = FP32_BIAS - FP16_BIAS;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_INF  = 16'h7C00;
    localparam logic [15:0] FP16_MAXF = 16'h7BFF;

    typedef enum logic [2:0] {ZERO, SUB, NORM, OVF, INF, NAN} lane_cls_e;
endpackage

// File: rtl/fp32_to_fp16_rne_lane.sv
// rtl/fp32_to_fp16_rne_lane.sv - one lane of the two-stage RNE converter datapath
// FP_CVT_SUBNORMAL_EN builds the S1 alignment shifter for FP16 subnormal results.
module fp32_to_fp16_rne_lane
    import fp_cvt_pkg::*;
#(
    parameter bit SAT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_adv1,
    input  logic        i_adv2,
    input  logic [31:0] i_data,
    output logic [15:0] o_data,
    output logic        o_ovf,
    output logic        o_unf,
    output logic        o_nan
);
    logic [7:0]  w_e;
    logic [22:0] w_f;
    lane_cls_e   w_cls;
    logic [14:0] w_mag;
    logic        w_rb;
    logic        w_st;

    assign w_e = i_data[30:23];
    assign w_f = i_data[22:0];

`ifdef FP_CVT_SUBNORMAL_EN
    logic [4:0]  w_sh;
    logic [49:0] w_shifted;
    assign w_sh      = 5'(8'd126 - w_e);
    assign w_shifted = {1'b1, w_f, 26'd0} >> w_sh;
`endif

    // w_mag is {exp16, mant10}; rounding adds straight into it so mantissa carry bumps the exponent.
    always_comb begin
        w_cls = NORM;
        w_mag = {5'(w_e - 8'(EXP_ADJ)), w_f[22:13]};
        w_rb  = w_f[12];
        w_st  = |w_f[11:0];
        if (w_e == 8'hFF) begin
            w_cls = (w_f != 23'd0) ? NAN : INF;
            w_mag = '0;
            w_rb  = 1'b0;
            w_st  = 1'b0;
        end else if (w_e > 8'(EXP_ADJ + 30)) begin
            w_cls = OVF;
            w_mag = '0;
            w_rb  = 1'b0;
            w_st  = 1'b0;
        end else if (w_e == 8'd0) begin
            w_cls = (w_f != 23'd0) ? SUB : ZERO;
            w_mag = '0;
            w_rb  = 1'b0;
            w_st  = 1'b0;
        end else if (w_e <= 8'(EXP_ADJ)) begin
            w_cls = SUB;
            w_mag = '0;
            w_rb  = 1'b0;
            w_st  = 1'b0;
`ifdef FP_CVT_SUBNORMAL_EN
            if (w_e >= 8'd101) begin
                w_mag = {5'd0, w_shifted[35:26]};
                w_rb  = w_shifted[25];
                w_st  = |w_shifted[24:0];
            end
`endif
        end
    end

    lane_cls_e   r_cls;
    logic        r_sign;
    logic [14:0] r_mag;
    logic        r_rb;
    logic        r_st;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cls  <= ZERO;
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_rb   <= 1'b0;
            r_st   <= 1'b0;
        end else if (i_adv1) begin
            r_cls  <= w_cls;
            r_sign <= i_data[31];
            r_mag  <= w_mag;
            r_rb   <= w_rb;
            r_st   <= w_st;
        end
    end

    logic        w_inc;
    logic [14:0] w_rnd;
    logic [14:0] w_ovf_mag;
    logic [15:0] w_res;
    logic        w_ovf;
    logic        w_unf;
    logic        w_nan;

    assign w_inc     = r_rb & (r_st | r_mag[0]);
    assign w_rnd     = r_mag + 15'(w_inc);
    assign w_ovf_mag = SAT ? FP16_MAXF[14:0] : FP16_INF[14:0];

    always_comb begin
        w_res = {r_sign, 15'd0};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_nan = 1'b0;
        case (r_cls)
            NORM: begin
                if (w_rnd[14:10] == 5'h1F) begin
                    w_res = {r_sign, w_ovf_mag};
                    w_ovf = 1'b1;
                end else begin
                    w_res = {r_sign, w_rnd};
                end
            end
            SUB: begin
                w_res = {r_sign, w_rnd};
                w_unf = (w_rnd == 15'd0) | r_rb | r_st;
            end
            OVF: begin
                w_res = {r_sign, w_ovf_mag};
                w_ovf = 1'b1;
            end
            INF:  w_res = {r_sign, FP16_INF[14:0]};
            NAN: begin
                w_res = {r_sign, FP16_QNAN[14:0]};
                w_nan = 1'b1;
            end
            default: w_res = {r_sign, 15'd0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data <= '0;
            o_ovf  <= 1'b0;
            o_unf  <= 1'b0;
            o_nan  <= 1'b0;
        end else if (i_adv2) begin
            o_data <= w_res;
            o_ovf  <= w_ovf;
            o_unf  <= w_unf;
            o_nan  <= w_nan;
        end
    end
endmodule

// File: rtl/fp32_to_fp16_pipe.sv
// rtl/fp32_to_fp16_pipe.sv - multi-lane FP32->FP16 RNE converter with two-stage valid/ready pipeline
// FP_CVT_SUBNORMAL_EN (in the lane) enables subnormal FP16 outputs instead of flush-to-zero.
module fp32_to_fp16_pipe
    import fp_cvt_pkg::*;
#(
    parameter int LANES = 4,
    parameter int SAT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*LANES-1:0]   out_data,
    output logic [LANES-1:0]      out_ovf,
    output logic [LANES-1:0]      out_unf,
    output logic [LANES-1:0]      out_nan
);
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_adv1;
    logic w_adv2;

    assign w_adv2    = !r_s2_valid || out_ready;
    assign w_adv1    = !r_s1_valid || w_adv2;
    assign in_ready  = w_adv1;
    assign out_valid = r_s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_adv1) r_s1_valid <= in_valid;
            if (w_adv2) r_s2_valid <= r_s1_valid;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fp32_to_fp16_rne_lane #(.SAT(SAT != 0)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_adv1 (w_adv1),
            .i_adv2 (w_adv2),
            .i_data (in_data[32*g +: 32]),
            .o_data (out_data[16*g +: 16]),
            .o_ovf  (out_ovf[g]),
            .o_unf  (out_unf[g]),
            .o_nan  (out_nan[g])
        );
    end
endmodule

// File: tb/tb_fp32_to_fp16_pipe.sv
// tb/tb_fp32_to_fp16_pipe.sv - directed and random bench for fp32_to_fp16_pipe against an arithmetic model
module tb_fp32_to_fp16_pipe;
    localparam int LANES = 4;
    localparam int SAT   = 0;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [32*LANES-1:0]   in_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [16*LANES-1:0]   out_data;
    logic [LANES-1:0]      out_ovf;
    logic [LANES-1:0]      out_unf;
    logic [LANES-1:0]      out_nan;

    int n_assert = 0;
    int n_fail   = 0;

    logic [16*LANES-1:0] q_data[$];
    logic [LANES-1:0]    q_ovf[$];
    logic [LANES-1:0]    q_unf[$];
    logic [LANES-1:0]    q_nan[$];

    fp32_to_fp16_pipe #(.LANES(LANES), .SAT(SAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_nan   (out_nan)
    );

    always #5 clk = ~clk;

    // Value = sig * 2^(e-150); quantise to the FP16 grid (2^(E-10) normal, 2^-24 subnormal) with RNE.
    function automatic logic [18:0] ref_cvt(input logic [31:0] x);
        logic        s;
        int          e, ue, qe, k, enc;
        longint      sig, units, rem, half;
        bit          sub, inexact;
        s = x[31];
        e = int'(x[30:23]);
        if (e == 255) return (x[22:0] != 0) ? {3'b100, s, 15'h7E00} : {3'b000, s, 15'h7C00};
        if (e == 0) return {1'b0, (x[22:0] != 0), 1'b0, s, 15'h0000};
        sig = 64'(1) << 23 | longint'(x[22:0]);
        ue  = e - 127;
        sub = (ue < -14);
`ifndef FP_CVT_SUBNORMAL_EN
        if (sub) return {3'b010, s, 15'h0000};
`endif
        qe = sub ? -24 : ue - 10;
        k  = qe - (e - 150);
        if (k >= 40) begin
            units   = 0;
            inexact = 1;
        end else begin
            units   = sig >> k;
            rem     = sig - (units << k);
            half    = 64'(1) << (k - 1);
            inexact = (rem != 0);
            if (rem > half || (rem == half && units[0])) units = units + 1;
        end
        enc = sub ? int'(units) : ((ue + 15) << 10) + int'(units) - 1024;
        if (!sub && enc >= 'h7C00) return {3'b001, s, (SAT != 0) ? 15'h7BFF : 15'h7C00};
        return {1'b0, sub && (enc == 0 || inexact), 1'b0, s, enc[14:0]};
    endfunction

    task automatic push_expected(input logic [32*LANES-1:0] d);
        logic [16*LANES-1:0] ed;
        logic [LANES-1:0]    eo, eu, en;
        logic [18:0]         r;
        for (int l = 0; l < LANES; l++) begin
            r = ref_cvt(d[32*l +: 32]);
            ed[16*l +: 16] = r[15:0];
            eo[l] = r[16];
            eu[l] = r[17];
            en[l] = r[18];
        end
        q_data.push_back(ed);
        q_ovf.push_back(eo);
        q_unf.push_back(eu);
        q_nan.push_back(en);
    endtask

    task automatic check_pop();
        logic [16*LANES-1:0] ed;
        logic [LANES-1:0]    eo, eu, en;
        n_assert++;
        assert (q_data.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_beat observed=%h expected=none", out_data);
        end
        if (q_data.size() > 0) begin
            ed = q_data.pop_front();
            eo = q_ovf.pop_front();
            eu = q_unf.pop_front();
            en = q_nan.pop_front();
            n_assert++;
            assert (out_data === ed) else begin
                n_fail++;
                $error("FAIL out_data observed=%h expected=%h", out_data, ed);
            end
            n_assert++;
            assert ({out_ovf, out_unf, out_nan} === {eo, eu, en}) else begin
                n_fail++;
                $error("FAIL flags(ovf,unf,nan) observed=%b_%b_%b expected=%b_%b_%b",
                       out_ovf, out_unf, out_nan, eo, eu, en);
            end
        end
    endtask

    // Handshakes are sampled at the falling edge, then time advances to just past the rising edge.
    task automatic step(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready && !rst;
        if (out_valid && out_ready && !rst) check_pop();
        if (acc) push_expected(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q_data.size() > 0; i++) step(acc);
        n_assert++;
        assert (q_data.size() == 0) else begin
            n_fail++;
            $error("FAIL drain_timeout observed=%0d pending expected=0", q_data.size());
        end
    endtask

    function automatic logic [31:0] rnd_fp();
        int unsigned pick;
        logic [7:0]  e;
        logic [22:0] f;
        pick = $urandom_range(0, 9);
        f    = 23'($urandom);
        case (pick)
            0: e = 8'd0;
            1: e = 8'd255;
            2, 3: e = 8'($urandom_range(95, 115));
            4, 5: e = 8'($urandom_range(138, 145));
            default: e = 8'($urandom_range(100, 150));
        endcase
        if (pick == 6) f[12:0] = 13'h1000;
        if (pick == 7) f[12:0] = 13'h1FFF;
        return {1'($urandom), e, f};
    endfunction

    function automatic logic [32*LANES-1:0] rnd_beat();
        logic [32*LANES-1:0] b;
        for (int l = 0; l < LANES; l++) b[32*l +: 32] = rnd_fp();
        return b;
    endfunction

    initial begin : main
        bit acc;
        int cnt;
        int sent;
        logic [32*LANES-1:0] beats[8];

        // Reset, with an input offered during reset that must be ignored
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = {4{32'h3F800000}};
        step(acc);
        step(acc);
        in_valid = 1'b0;
        n_assert++;
        assert (out_valid === 1'b0) else begin n_fail++; $error("FAIL reset_out_valid observed=%b expected=0", out_valid); end
        n_assert++;
        assert (out_data === '0) else begin n_fail++; $error("FAIL reset_out_data observed=%h expected=0", out_data); end
        n_assert++;
        assert ({out_ovf, out_unf, out_nan} === '0) else begin n_fail++; $error("FAIL reset_flags observed=%b expected=0", {out_ovf, out_unf, out_nan}); end
        n_assert++;
        assert (in_ready === 1'b1) else begin n_fail++; $error("FAIL reset_in_ready observed=%b expected=1", in_ready); end
        rst = 1'b0;

        // First beat: constants and 2-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {32'h3F803000, 32'h3F801000, 32'hC0000000, 32'h3F800000};
        step(acc);
        in_valid = 1'b0;
        n_assert++;
        assert (out_valid === 1'b0) else begin n_fail++; $error("FAIL latency_early observed=%b expected=0", out_valid); end
        step(acc);
        n_assert++;
        assert (out_valid === 1'b1) else begin n_fail++; $error("FAIL latency_2 observed=%b expected=1", out_valid); end
        n_assert++;
        assert (out_data === 64'h3C02_3C00_C000_3C00) else begin n_fail++; $error("FAIL first_beat observed=%h expected=3c023c00c0003c00", out_data); end
        n_assert++;
        assert ({out_ovf, out_unf, out_nan} === '0) else begin n_fail++; $error("FAIL first_flags observed=%b expected=0", {out_ovf, out_unf, out_nan}); end

        // Rounding boundaries, specials and subnormals back to back
        in_valid = 1'b1;
        in_data  = {32'hFF800000, 32'h7FC00001, 32'h477FF000, 32'h477FE000};
        step(acc);
        in_data  = {32'h00000000, 32'h387FF000, 32'h33800000, 32'h00000001};
        step(acc);
        in_data  = {32'h80000000, 32'hC77FF000, 32'h47800000, 32'h3F7FF000};
        step(acc);
        drain();

        // Stall from an empty pipe: exactly two beats accepted, in_ready follows out_ready
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            in_data = rnd_beat();
            step(acc);
            if (acc) cnt++;
        end
        n_assert++;
        assert (cnt == 2) else begin n_fail++; $error("FAIL stall_accepts observed=%0d expected=2", cnt); end
        n_assert++;
        assert (in_ready === 1'b0) else begin n_fail++; $error("FAIL stall_in_ready observed=%b expected=0", in_ready); end
        out_ready = 1'b1;
        #1;
        n_assert++;
        assert (in_ready === 1'b1) else begin n_fail++; $error("FAIL unstall_in_ready observed=%b expected=1", in_ready); end
        drain();

        // Eight back-to-back beats with out_ready low for cycles 3..6
        for (int b = 0; b < 8; b++) beats[b] = rnd_beat();
        sent = 0;
        for (int i = 0; i < 40 && (sent < 8 || i < 12); i++) begin
            out_ready = !(i >= 3 && i <= 6);
            in_valid  = (sent < 8);
            in_data   = beats[sent % 8];
            if (i == 5) begin
                #1;
                n_assert++;
                assert (in_ready === 1'b0) else begin n_fail++; $error("FAIL bp_in_ready observed=%b expected=0", in_ready); end
            end
            step(acc);
            if (acc) sent++;
        end
        n_assert++;
        assert (sent == 8) else begin n_fail++; $error("FAIL bp_sent observed=%0d expected=8", sent); end
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 200; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = rnd_beat();
            step(acc);
        end
        drain();

        // Reset with two beats in flight: neither may appear
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6 && cnt < 2; i++) begin
            in_data = rnd_beat();
            step(acc);
            if (acc) cnt++;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step(acc);
        n_assert++;
        assert (out_valid === 1'b0) else begin n_fail++; $error("FAIL midreset_out_valid observed=%b expected=0", out_valid); end
        q_data.delete();
        q_ovf.delete();
        q_unf.delete();
        q_nan.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(acc);
            n_assert++;
            assert (out_valid === 1'b0) else begin n_fail++; $error("FAIL midreset_ghost observed=%b expected=0", out_valid); end
        end

        // Pipeline still works after reset
        in_valid = 1'b1;
        in_data  = rnd_beat();
        step(acc);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
